l1_stream_ptr_v2: RTL and testbench
===================================

# l1_stream_ptr_v2

Second-generation L1 stream pointer for one stream of the multi-stream buffer. It tracks the global read pointer (cacheline id + offset) shared by `nports` read ports and keeps up to `ncl` lines in flight or resident. It issues addressed cacheline requests to L2. Unlike the first generation, it owns a programmable stream length, an explicit IDLE/ACTIVE/DRAIN state machine, outstanding-request tracking with response backpressure, and last-line read capping, so stream termination no longer depends on an external end flag.

## Interface
Parameters:
- `nports`, 8, read ports; must satisfy 1 ≤ nports ≤ cl_size.
- `ncl`, 16, lines per stream; must be a power of two and ≥ 2.
- `cl_size`, 8, reads per cacheline; must be a power of two.
- `min_cl`, 2, resident lines required before reads are accepted in ACTIVE; must satisfy 2 ≤ min_cl ≤ ncl.
- `len_width`, 16, width of the stream length in lines.
- Derived: `ncl_width=$clog2(ncl+1)`, `clid_width=$clog2(ncl)`, `clofs_width=$clog2(cl_size)`, `width=clid_width+clofs_width`, `inc_width=$clog2(nports+1)`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `i_rst_v` / `i_rst_r`  in/out  1  stream start handshake.
- `i_rst_ea_b`  in  clid_width  first line id.
- `i_rst_len`  in  len_width  stream length in lines; 0 = unbounded.
- `i_rd_v` / `i_rd_r`  in/out  nports  per-port read handshake.
- `o_d`  out  width  global pointer {clid, clofs}.
- `o_single_v`  out  1  exactly one resident line.
- `o_clreq_v` / `o_clreq_r`  out/in  1  L2 line request.
- `o_clreq_clid`  out  clid_width  line id of the current request.
- `i_clrsp_v` / `i_clrsp_r`  in/out  1  L2 line response.
- `o_active`  out  1  state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse when the stream is fully consumed.

## Operation
Counters (all registered):
- `rcnt`: resident lines.
- `pend`: requests owed but not yet issued.
- `outst`: requests issued, response not yet received.
- `left`: lines not yet scheduled for request.
- `reqptr`: next line id to request.
- `clid`, `clofs`: the global pointer.
- Invariant: rcnt+pend+outst ≤ ncl.

States:
- **IDLE**
  - i_rd_r=0, o_clreq_v=0, i_clrsp_r=0.
  - A start handshake sets clid=reqptr=i_rst_ea_b and clofs=0.
  - If len=0: pend=ncl and left is ignored.
  - Otherwise: pend=min(ncl,len) and left=len−pend.
  - Next state is ACTIVE.
- **ACTIVE**
  - Read enable = rcnt ≥ min_cl.
  - When enabled, i_rd_r={nports{1}}.
  - Accepted reads advance the pointer by popcount(i_rd_v).
  - If clofs overflows, clid increments mod ncl and rcnt decrements.
  - On that carry, pend increments when len=0 or left≠0; left then decrements (when len≠0).
  - Go to DRAIN when len≠0, left=0 and pend=0.
- **DRAIN**
  - Read enable = rcnt ≥ min_cl, or (rcnt=1 and outst=0).
  - With rcnt=1, accepts are capped to the lowest-index valid ports, at most cl_size−clofs of them.
  - i_rd_r is 0 for all other ports.
  - When rcnt reaches 0 with outst=0: pulse o_done and return to IDLE.

Request and response channels:
- o_clreq_v = pend≠0 (in ACTIVE or DRAIN); o_clreq_clid = reqptr.
- A request handshake decrements pend, increments outst, and increments reqptr mod ncl.
- i_clrsp_r = outst≠0 (responses without an outstanding request stall).
- A response handshake decrements outst and increments rcnt.

Restart and simultaneous events:
- i_rst_r = (state=IDLE) or (outst=0); mid-stream restart aborts the stream with no o_done.
- In a start-handshake cycle, i_rd_r=0 and no request handshake completes: o_clreq_v is forced 0.
- Simultaneous inc and dec on any counter leaves it unchanged.

Reset: all counters and the pointer go to 0, state goes to IDLE, i_rst_r=1, and every other output is 0.

## Timing
- All state is updated on the rising clk edge.
- o_d, o_single_v, o_active and o_done are registered.
- o_clreq_v is combinational from pend and state; i_rd_r is combinational from registered state and i_rd_v.
- Start handshake in cycle N → o_active and o_clreq_v are high in N+1.
- Response in N → rcnt is visible in N+1 → reads can be accepted in N+1.
- Read accept in N → o_d updated in N+1; a carry request is visible in N+1.
- o_done is high for exactly one cycle, the cycle after the last read.

## Test plan
Defaults: nports=8, ncl=16, cl_size=8, min_cl=2.
1. Deassert reset → o_d=0, o_clreq_v=0, o_active=0, o_done=0, i_rst_r=1, i_rd_r=0x00.
2. Start with ea_b=5, len=0, o_clreq_r=1 → 16 requests, clids 5..15 then 0..4. Return 1 response → i_rd_r=0x00; return a 2nd → i_rd_r=0xFF the next cycle.
3. Unbounded stream, rcnt=16, 8 reads at o_d={5,0} → o_d={6,0}, rcnt=15, one request with clid 5. Add a response in the same cycle as a carry → rcnt unchanged.
4. Start with len=3 and consume 2 lines → DRAIN. At rcnt=1, clofs=5, i_rd_v=0xFF → i_rd_r=0x07, o_d={clid+1,0}, rcnt=0, o_done=1 for one cycle, then IDLE.
5. Stream with outst=2 plus a new i_rst_v → i_rst_r=0 until both responses return, then the handshake completes; reads are blocked that cycle and the pointer = new ea_b.
6. Assert reset mid-DRAIN → all outputs return to their reset values immediately (asynchronously).

Source files
------------

// File: rtl/l1_stream_ptr_v2.sv
// Global read pointer and L2 line-request tracker for one stream of the L1 buffer,
// with programmable length, IDLE/ACTIVE/DRAIN control and last-line read capping.
module l1_stream_ptr_v2 #(
    parameter int nports    = 8,
    parameter int ncl       = 16,
    parameter int cl_size   = 8,
    parameter int min_cl    = 2,
    parameter int len_width = 16,
    localparam int ncl_width   = $clog2(ncl + 1),
    localparam int clid_width  = $clog2(ncl),
    localparam int clofs_width = $clog2(cl_size),
    localparam int width       = clid_width + clofs_width,
    localparam int inc_width   = $clog2(nports + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rst_v,
    output logic                  i_rst_r,
    input  logic [clid_width-1:0] i_rst_ea_b,
    input  logic [len_width-1:0]  i_rst_len,
    input  logic [nports-1:0]     i_rd_v,
    output logic [nports-1:0]     i_rd_r,
    output logic [width-1:0]      o_d,
    output logic                  o_single_v,
    output logic                  o_clreq_v,
    input  logic                  o_clreq_r,
    output logic [clid_width-1:0] o_clreq_clid,
    input  logic                  i_clrsp_v,
    output logic                  i_clrsp_r,
    output logic                  o_active,
    output logic                  o_done
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                  state;
    logic [ncl_width-1:0]    rcnt, pend, outst;
    logic [ncl_width-1:0]    rcnt_nxt, pend_nxt, outst_nxt;
    logic [len_width-1:0]    left;
    logic                    len_zero;
    logic [clid_width-1:0]   reqptr, clid;
    logic [clofs_width-1:0]  clofs;

    logic                    start_hs, rd_open, rd_cap, req_hs, rsp_hs, carry;
    logic                    pend_inc, left_dec;
    logic [nports-1:0]       rd_r, rd_acc;
    logic [inc_width-1:0]    rd_inc;
    logic [clofs_width:0]    ofs_sum, cap_lim, taken;

    function automatic logic [inc_width-1:0] popcount(input logic [nports-1:0] v);
        logic [inc_width-1:0] n;
        n = '0;
        for (int i = 0; i < nports; i++) n = n + inc_width'(v[i]);
        return n;
    endfunction

    // Restart is only safe once no L2 response can still arrive for the old stream.
    assign i_rst_r  = (state == IDLE) || (outst == '0);
    assign start_hs = i_rst_v && i_rst_r;

    always_comb begin
        rd_open = 1'b0;
        rd_cap  = 1'b0;
        case (state)
            ACTIVE: rd_open = (rcnt >= ncl_width'(min_cl));
            DRAIN: begin
                rd_open = (rcnt >= ncl_width'(min_cl)) ||
                          ((rcnt == ncl_width'(1)) && (outst == '0));
                rd_cap  = (rcnt == ncl_width'(1));
            end
            default: ;
        endcase
        if (start_hs) rd_open = 1'b0;
    end

    // On the final line only the reads that fit before the line end are granted.
    always_comb begin
        rd_r    = '0;
        taken   = '0;
        cap_lim = (clofs_width + 1)'(cl_size) - {1'b0, clofs};
        if (rd_open) begin
            if (!rd_cap) begin
                rd_r = '1;
            end else begin
                for (int p = 0; p < nports; p++) begin
                    if (i_rd_v[p] && (taken < cap_lim)) begin
                        rd_r[p] = 1'b1;
                        taken   = taken + 1'b1;
                    end
                end
            end
        end
    end

    assign i_rd_r  = rd_r;
    assign rd_acc  = i_rd_v & rd_r;
    assign rd_inc  = popcount(rd_acc);
    assign ofs_sum = {1'b0, clofs} + (clofs_width + 1)'(rd_inc);
    assign carry   = ofs_sum[clofs_width];

    assign o_clreq_v    = (state != IDLE) && (pend != '0) && !start_hs;
    assign o_clreq_clid = reqptr;
    assign req_hs       = o_clreq_v && o_clreq_r;
    assign i_clrsp_r    = (state != IDLE) && (outst != '0);
    assign rsp_hs       = i_clrsp_v && i_clrsp_r;

    assign pend_inc  = carry && (len_zero || (left != '0));
    assign left_dec  = carry && !len_zero && (left != '0);
    assign rcnt_nxt  = rcnt + ncl_width'(rsp_hs) - ncl_width'(carry);
    assign pend_nxt  = pend + ncl_width'(pend_inc) - ncl_width'(req_hs);
    assign outst_nxt = outst + ncl_width'(req_hs) - ncl_width'(rsp_hs);

    assign o_d        = {clid, clofs};
    assign o_single_v = (rcnt == ncl_width'(1));
    assign o_active   = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rcnt     <= '0;
            pend     <= '0;
            outst    <= '0;
            left     <= '0;
            len_zero <= 1'b0;
            reqptr   <= '0;
            clid     <= '0;
            clofs    <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (start_hs) begin
                state    <= ACTIVE;
                clid     <= i_rst_ea_b;
                reqptr   <= i_rst_ea_b;
                clofs    <= '0;
                rcnt     <= '0;
                outst    <= '0;
                len_zero <= (i_rst_len == '0);
                if (i_rst_len == '0) begin
                    pend <= ncl_width'(ncl);
                    left <= '0;
                end else if ({1'b0, i_rst_len} >= (len_width + 1)'(ncl)) begin
                    pend <= ncl_width'(ncl);
                    left <= i_rst_len - len_width'(ncl);
                end else begin
                    pend <= ncl_width'(i_rst_len);
                    left <= '0;
                end
            end else begin
                clofs <= ofs_sum[clofs_width-1:0];
                rcnt  <= rcnt_nxt;
                pend  <= pend_nxt;
                outst <= outst_nxt;
                if (carry)    clid   <= clid + 1'b1;
                if (req_hs)   reqptr <= reqptr + 1'b1;
                if (left_dec) left   <= left - 1'b1;
                case (state)
                    ACTIVE: if (!len_zero && (left == '0) && (pend == '0)) state <= DRAIN;
                    DRAIN: begin
                        if ((rcnt_nxt == '0) && (outst_nxt == '0)) begin
                            state  <= IDLE;
                            o_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_l1_stream_ptr_v2.sv
// Bench for l1_stream_ptr_v2: vector table, directed multi-cycle sequences and a
// randomized run against a counting model of the stream.
module tb_l1_stream_ptr_v2;

    localparam int NCL = 16;
    localparam int CLS = 8;
    localparam int MINCL = 2;

    logic        clk;
    logic        reset;
    logic        i_rst_v;
    logic        i_rst_r;
    logic [3:0]  i_rst_ea_b;
    logic [15:0] i_rst_len;
    logic [7:0]  i_rd_v;
    logic [7:0]  i_rd_r;
    logic [6:0]  o_d;
    logic        o_single_v;
    logic        o_clreq_v;
    logic        o_clreq_r;
    logic [3:0]  o_clreq_clid;
    logic        i_clrsp_v;
    logic        i_clrsp_r;
    logic        o_active;
    logic        o_done;

    l1_stream_ptr_v2 dut (
        .clk(clk), .reset(reset),
        .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_ea_b(i_rst_ea_b), .i_rst_len(i_rst_len),
        .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .o_d(o_d), .o_single_v(o_single_v),
        .o_clreq_v(o_clreq_v), .o_clreq_r(o_clreq_r), .o_clreq_clid(o_clreq_clid),
        .i_clrsp_v(i_clrsp_v), .i_clrsp_r(i_clrsp_r), .o_active(o_active), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst_v, ea, len, rd_v, req_r, rsp_v;
        int e_rst_r, e_rd_r, e_req_v, e_clid, e_rsp_r, e_d, e_single, e_active, e_done;
    } vec_t;

    vec_t vecs[10];
    int n_checks = 0;
    int n_errors = 0;

    // model of the stream: start line, length, reads taken, requests and responses seen
    int m_mode, m_ea, m_len, m_rd, m_nreq, m_nrsp, m_done;
    int cons, res, outs, sched, pend, e_rst_r, start, rd_ok, cap, k, acc, req, rsp;
    int lines, guard;
    logic [7:0] e_rd_r;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string t, input int rst_r, rd_r, req_v, clid, rsp_r,
                           d, single, active, done);
        chk({t, ".rst_r"},  int'(i_rst_r),      rst_r);
        chk({t, ".rd_r"},   int'(i_rd_r),       rd_r);
        chk({t, ".req_v"},  int'(o_clreq_v),    req_v);
        chk({t, ".clid"},   int'(o_clreq_clid), clid);
        chk({t, ".rsp_r"},  int'(i_clrsp_r),    rsp_r);
        chk({t, ".d"},      int'(o_d),          d);
        chk({t, ".single"}, int'(o_single_v),   single);
        chk({t, ".active"}, int'(o_active),     active);
        chk({t, ".done"},   int'(o_done),       done);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // len=3 stream from line 14: fill, drain, capped final line and done pulse
        vecs[0] = '{1, 14, 3, 'h00, 1, 0,   1, 'h00, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 'hFF, 1, 0,    1, 'h00, 1, 14, 0, 112, 0, 1, 0};
        vecs[2] = '{0, 0, 0, 'hFF, 1, 1,    0, 'h00, 1, 15, 1, 112, 0, 1, 0};
        vecs[3] = '{0, 0, 0, 'hFF, 1, 1,    0, 'h00, 1, 0, 1, 112, 1, 1, 0};
        vecs[4] = '{0, 0, 0, 'hFF, 1, 1,    0, 'hFF, 0, 1, 1, 112, 0, 1, 0};
        vecs[5] = '{0, 0, 0, 'h1F, 1, 0,    1, 'hFF, 0, 1, 0, 120, 0, 1, 0};
        vecs[6] = '{0, 0, 0, 'hFF, 1, 0,    1, 'hFF, 0, 1, 0, 125, 0, 1, 0};
        vecs[7] = '{0, 0, 0, 'hFF, 1, 0,    1, 'h07, 0, 1, 0, 5, 1, 1, 0};
        vecs[8] = '{0, 0, 0, 'hFF, 1, 0,    1, 'h00, 0, 1, 0, 8, 0, 0, 1};
        vecs[9] = '{0, 0, 0, 'h00, 1, 0,    1, 'h00, 0, 1, 0, 8, 0, 0, 0};

        reset = 1'b0;
        i_rst_v = 1'b0; i_rst_ea_b = '0; i_rst_len = '0;
        i_rd_v = 8'hFF; o_clreq_r = 1'b0; i_clrsp_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            i_rst_v    = (vecs[i].rst_v != 0);
            i_rst_ea_b = 4'(vecs[i].ea);
            i_rst_len  = 16'(vecs[i].len);
            i_rd_v     = 8'(vecs[i].rd_v);
            o_clreq_r  = (vecs[i].req_r != 0);
            i_clrsp_v  = (vecs[i].rsp_v != 0);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rst_r, vecs[i].e_rd_r, vecs[i].e_req_v,
                    vecs[i].e_clid, vecs[i].e_rsp_r, vecs[i].e_d, vecs[i].e_single,
                    vecs[i].e_active, vecs[i].e_done);
            step();
        end

        // unbounded stream from line 5: 16 requests wrapping through 0
        i_rst_v = 1'b1; i_rst_ea_b = 4'd5; i_rst_len = 16'd0;
        o_clreq_r = 1'b1; i_rd_v = 8'h00; i_clrsp_v = 1'b0;
        @(negedge clk);
        chk("start_rst_r", int'(i_rst_r), 1);
        step();
        i_rst_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("req%0d.v", i), int'(o_clreq_v), 1);
            chk($sformatf("req%0d.clid", i), int'(o_clreq_clid), (5 + i) % 16);
            step();
        end
        @(negedge clk);
        chk("req_after16", int'(o_clreq_v), 0);
        step();
        o_clreq_r = 1'b0;
        i_clrsp_v = 1'b1;
        step();
        i_clrsp_v = 1'b0; i_rd_v = 8'hFF;
        @(negedge clk);
        chk("rd_r_one_line", int'(i_rd_r), 'h00);
        step();
        i_rd_v = 8'h00; i_clrsp_v = 1'b1;
        step();
        i_clrsp_v = 1'b0;
        @(negedge clk);
        chk("rd_r_two_lines", int'(i_rd_r), 'hFF);
        step();
        i_clrsp_v = 1'b1;
        repeat (14) step();
        i_clrsp_v = 1'b0;
        @(negedge clk);
        chk("full_d", int'(o_d), 40);
        chk("full_req_v", int'(o_clreq_v), 0);
        step();
        i_rd_v = 8'hFF;
        step();
        i_rd_v = 8'h00;
        @(negedge clk);
        chk("carry_d", int'(o_d), 48);
        chk("carry_req_v", int'(o_clreq_v), 1);
        chk("carry_req_clid", int'(o_clreq_clid), 5);
        step();
        o_clreq_r = 1'b1;
        step();
        o_clreq_r = 1'b0;
        @(negedge clk);
        chk("one_outst_rsp_r", int'(i_clrsp_r), 1);
        step();
        i_rd_v = 8'hFF; i_clrsp_v = 1'b1;
        step();
        i_rd_v = 8'h00; i_clrsp_v = 1'b0;
        @(negedge clk);
        chk("simul_d", int'(o_d), 56);
        chk("simul_rsp_r", int'(i_clrsp_r), 0);
        step();
        // rcnt must still be 15: exactly 14 more lines drain before a single line remains
        i_rd_v = 8'hFF; lines = 0; guard = 0;
        @(negedge clk);
        while (!o_single_v && guard < 40) begin
            if (i_rd_r == 8'hFF) lines++;
            step();
            @(negedge clk);
            guard++;
        end
        chk("lines_to_single", lines, 14);
        chk("single_rd_r", int'(i_rd_r), 'h00);
        chk("single_d", int'(o_d), 40);
        step();

        // restart while two responses are owed
        i_rd_v = 8'h00; o_clreq_r = 1'b1;
        step();
        step();
        o_clreq_r = 1'b0;
        i_rst_v = 1'b1; i_rst_ea_b = 4'd9; i_rst_len = 16'd4;
        @(negedge clk);
        chk("restart_outst2", int'(i_rst_r), 0);
        step();
        i_clrsp_v = 1'b1;
        @(negedge clk);
        chk("restart_outst2b", int'(i_rst_r), 0);
        step();
        @(negedge clk);
        chk("restart_outst1", int'(i_rst_r), 0);
        step();
        i_clrsp_v = 1'b0; i_rd_v = 8'hFF;
        @(negedge clk);
        chk("restart_rst_r", int'(i_rst_r), 1);
        chk("restart_rd_block", int'(i_rd_r), 'h00);
        chk("restart_req_block", int'(o_clreq_v), 0);
        step();
        i_rst_v = 1'b0; i_rd_v = 8'h00;
        @(negedge clk);
        chk("restart_d", int'(o_d), 72);
        chk("restart_active", int'(o_active), 1);
        chk("restart_req_clid", int'(o_clreq_clid), 9);
        step();

        // run the len=4 stream into DRAIN, then reset asynchronously
        o_clreq_r = 1'b1; i_clrsp_v = 1'b1;
        repeat (6) step();
        o_clreq_r = 1'b0; i_clrsp_v = 1'b0; i_rd_v = 8'hFF;
        @(negedge clk);
        chk("drain_active", int'(o_active), 1);
        chk("drain_rd_r", int'(i_rd_r), 'hFF);
        #2 reset = 1'b0;
        #1 chk_all("async_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1; i_rd_v = 8'h00;

        m_mode = 0; m_ea = 0; m_len = 0; m_rd = 0; m_nreq = 0; m_nrsp = 0; m_done = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            i_rst_v    = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            i_rst_ea_b = 4'($urandom_range(0, 15));
            i_rst_len  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            i_rd_v     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            o_clreq_r  = ($urandom_range(0, 3) != 0);
            i_clrsp_v  = ($urandom_range(0, 2) != 0);
            @(negedge clk);

            cons  = m_rd / CLS;
            res   = m_nrsp - cons;
            outs  = m_nreq - m_nrsp;
            sched = NCL + cons;
            if (m_len != 0 && m_len < sched) sched = m_len;
            pend  = sched - m_nreq;
            e_rst_r = (m_mode == 0 || outs == 0) ? 1 : 0;
            start = (i_rst_v && e_rst_r != 0) ? 1 : 0;
            rd_ok = 0;
            cap   = 0;
            if (m_mode == 1) rd_ok = (res >= MINCL) ? 1 : 0;
            if (m_mode == 2) begin
                rd_ok = (res >= MINCL || (res == 1 && outs == 0)) ? 1 : 0;
                cap   = (res == 1) ? 1 : 0;
            end
            if (start != 0) rd_ok = 0;
            e_rd_r = 8'h00;
            if (rd_ok != 0 && cap == 0) e_rd_r = 8'hFF;
            if (rd_ok != 0 && cap != 0) begin
                k = CLS - (m_rd % CLS);
                for (int p = 0; p < 8; p++) begin
                    if (i_rd_v[p] && k > 0) begin
                        e_rd_r[p] = 1'b1;
                        k--;
                    end
                end
            end

            chk_all($sformatf("rnd%0d", cyc), e_rst_r, int'(e_rd_r),
                    (m_mode != 0 && pend > 0 && start == 0) ? 1 : 0,
                    (m_ea + m_nreq) % NCL,
                    (m_mode != 0 && outs > 0) ? 1 : 0,
                    ((m_ea + cons) % NCL) * CLS + (m_rd % CLS),
                    (res == 1) ? 1 : 0,
                    (m_mode != 0) ? 1 : 0,
                    m_done);

            acc = $countones(i_rd_v & e_rd_r);
            req = (m_mode != 0 && pend > 0 && start == 0 && o_clreq_r) ? 1 : 0;
            rsp = (m_mode != 0 && outs > 0 && i_clrsp_v) ? 1 : 0;
            m_done = 0;
            if (start != 0) begin
                m_mode = 1; m_ea = int'(i_rst_ea_b); m_len = int'(i_rst_len);
                m_rd = 0; m_nreq = 0; m_nrsp = 0;
            end else begin
                m_rd   += acc;
                m_nreq += req;
                m_nrsp += rsp;
                if (m_mode == 1) begin
                    if (m_len != 0 && sched == m_len && pend == 0) m_mode = 2;
                end else if (m_mode == 2) begin
                    if (m_rd / CLS == m_len) begin
                        m_mode = 0;
                        m_done = 1;
                    end
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
